unary_bin_decoder: RTL and testbench

Converts IDIM parallel unary bitstreams back to binary by counting ones over a fixed window of 2^BWID enabled cycles, one counter per lane. It is the output-side counterpart of the Sobol/comparator bitstream generators feeding the hybrid linear layers. It sits after stochastic compute arrays whose results must be returned to binary for buffering or the next layer. A start/valid/ready handshake frames each window.

---
 rtl/unary_bin_decoder_pkg.sv | 15 +
 rtl/bs_lane_cnt.sv | 42 ++++
 rtl/unary_bin_decoder.sv | 109 ++++++++++
 tb/tb_unary_bin_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unary_bin_decoder_pkg.sv
// Shared types and helpers for the unary-to-binary bitstream decoder.
package unary_bin_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of enabled samples in one decode window.
  function automatic int unsigned win_len(input int unsigned bwid);
    return 32'd1 << bwid;
  endfunction

endpackage

// File: rtl/bs_lane_cnt.sv
// One lane: ones counter over the window plus a saturating result register.
module bs_lane_cnt #(
  parameter int unsigned BWID = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic            sample,
  input  logic            load,
  output logic [BWID-1:0] res
);

  localparam int unsigned CW = BWID + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] sum_c;

  // The sum includes the current sample so the final load sees the last bit.
  assign sum_c = cnt + CW'(sample);

  // Lane ones counter; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sum_c;
    end
  end

  // Result register; a full count of 2^BWID clips to the maximum code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else if (load) begin
      res <= sum_c[BWID] ? {BWID{1'b1}} : sum_c[BWID-1:0];
    end
  end

endmodule

// File: rtl/unary_bin_decoder.sv
// Decodes IDIM unary bitstreams to binary over a window of 2^BWID enabled cycles.
module unary_bin_decoder
  import unary_bin_decoder_pkg::*;
#(
  parameter int unsigned IDIM = 64,
  parameter int unsigned BWID = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      clear,
  input  logic                      iEn,
  input  logic [IDIM-1:0]           iBit,
  input  logic                      oReady,
  output logic                      oValid,
  output logic                      busy,
  output logic [IDIM-1:0][BWID-1:0] oData
);

  localparam int unsigned WIN = win_len(BWID);
  localparam logic [BWID-1:0] WMAX = BWID'(WIN - 1);

  state_t          state;
  state_t          state_nxt;
  logic [BWID-1:0] wcnt;
  logic            lane_clr_c;
  logic            cnt_en_c;
  logic            load_c;

  // Next-state and per-cycle counter controls; clear overrides everything.
  always_comb begin
    state_nxt  = state;
    lane_clr_c = 1'b0;
    cnt_en_c   = 1'b0;
    load_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        lane_clr_c = 1'b1;
        if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (iEn) begin
          cnt_en_c = 1'b1;
          if (wcnt == WMAX) begin
            load_c    = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        lane_clr_c = 1'b1;
        if (oReady) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        lane_clr_c = 1'b1;
        state_nxt  = ST_IDLE;
      end
    endcase
    if (clear) begin
      state_nxt  = ST_IDLE;
      lane_clr_c = 1'b1;
      cnt_en_c   = 1'b0;
      load_c     = 1'b0;
    end
  end

  // State register with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      oValid <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      oValid <= (state_nxt == ST_DONE);
      busy   <= (state_nxt != ST_IDLE);
    end
  end

  // Window sample counter, advancing only on enabled RUN cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (lane_clr_c) begin
      wcnt <= '0;
    end else if (cnt_en_c) begin
      wcnt <= wcnt + BWID'(1);
    end
  end

  for (genvar g = 0; g < IDIM; g++) begin : g_lane
    bs_lane_cnt #(
      .BWID(BWID)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (lane_clr_c),
      .en    (cnt_en_c),
      .sample(iBit[g]),
      .load  (load_c),
      .res   (oData[g])
    );
  end

endmodule

// File: tb/tb_unary_bin_decoder.sv
// Self-checking bench: behavioural window model plus directed and random windows.
module tb_unary_bin_decoder;

  localparam int unsigned IDIM = 2;
  localparam int unsigned BWID = 4;
  localparam int N = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic                      clear;
  logic                      iEn;
  logic [IDIM-1:0]           iBit;
  logic                      oReady;
  logic                      oValid;
  logic                      busy;
  logic [IDIM-1:0][BWID-1:0] oData;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  unary_bin_decoder #(.IDIM(IDIM), .BWID(BWID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .clear (clear),
    .iEn   (iEn),
    .iBit  (iBit),
    .oReady(oReady),
    .oValid(oValid),
    .busy  (busy),
    .oData (oData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 collecting samples, 2 holding a result.
  int m_phase = 0;
  int m_n = 0;
  int m_sum[IDIM];
  int m_data[IDIM];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_n = 0;
      for (int i = 0; i < IDIM; i++) begin
        m_sum[i] = 0;
        m_data[i] = 0;
      end
    end else if (clear) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_n = 0;
        for (int i = 0; i < IDIM; i++) m_sum[i] = 0;
      end
    end else if (m_phase == 1) begin
      if (iEn) begin
        m_n++;
        for (int i = 0; i < IDIM; i++) m_sum[i] += int'(iBit[i]);
        if (m_n == N) begin
          for (int i = 0; i < IDIM; i++) m_data[i] = (m_sum[i] > N - 1) ? N - 1 : m_sum[i];
          m_phase = 2;
        end
      end
    end else begin
      if (oReady) m_phase = 0;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_oValid", 32'(oValid), 32'(m_phase == 2));
      chk("model_busy", 32'(busy), 32'(m_phase != 0));
      for (int i = 0; i < IDIM; i++)
        chk($sformatf("model_oData%0d", i), 32'(oData[i]), 32'(m_data[i]));
    end
  end

  // Bit-reversed index: first-dimension Sobol point for a 4-bit window.
  function automatic logic [3:0] vdc(input int k);
    logic [3:0] kk;
    kk = 4'(k);
    return {kk[0], kk[1], kk[2], kk[3]};
  endfunction

  function automatic logic [IDIM-1:0] lane_bits(input int pat, input int k);
    logic [IDIM-1:0] b;
    b = '0;
    if (pat == 0) begin
      b[0] = 1'b1;
    end else if (pat == 1) begin
      b[0] = (k % 2 == 0);
      b[1] = (4'd11 > vdc(k));
    end else begin
      b = IDIM'($urandom);
    end
    return b;
  endfunction

  // Called at a negedge; start is sampled on the following edge (E0).
  task automatic do_window(input int pat, input int gap_at, input int gap_len, output int lat);
    int k;
    int cyc;
    int gap_left;
    start = 1'b1;
    iEn = 1'b1;
    iBit = IDIM'($urandom);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    cyc = 0;
    lat = -1;
    gap_left = gap_len;
    while (lat < 0 && cyc < 200) begin
      if (gap_left > 0 && k == gap_at) begin
        iEn = 1'b0;
        iBit = IDIM'($urandom);
        gap_left--;
      end else if (pat == 2 && $urandom_range(3) == 0) begin
        iEn = 1'b0;
        iBit = IDIM'($urandom);
      end else begin
        iEn = 1'b1;
        iBit = lane_bits(pat, k);
        k++;
      end
      @(negedge clk);
      cyc++;
      if (oValid) lat = cyc;
    end
    iEn = 1'b0;
    if (lat < 0) chk("window_timeout", 32'(cyc), 32'd0);
  endtask

  // Hold the result for a while with start pulsed, then accept (optionally with clear).
  task automatic accept(input int hold, input bit with_clr);
    for (int h = 0; h < hold; h++) begin
      oReady = 1'b0;
      start = 1'b1;
      @(negedge clk);
      chk("hold_oValid", 32'(oValid), 32'd1);
    end
    start = 1'b0;
    oReady = 1'b1;
    clear = with_clr;
    @(negedge clk);
    oReady = 1'b0;
    clear = 1'b0;
    chk("accept_busy", 32'(busy), 32'd0);
    chk("accept_oValid", 32'(oValid), 32'd0);
  endtask

  // Abort a window after 7 samples by clear or by reset.
  task automatic abort_window(input bit use_rst, input int exp0, input int exp1);
    start = 1'b1;
    iEn = 1'b1;
    iBit = IDIM'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      iEn = 1'b1;
      iBit = IDIM'($urandom);
      @(negedge clk);
    end
    if (!use_rst) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      chk("clear_busy", 32'(busy), 32'd0);
      for (int c = 0; c < 20; c++) begin
        iEn = 1'b1;
        iBit = IDIM'($urandom);
        @(negedge clk);
        chk("clear_oValid", 32'(oValid), 32'd0);
      end
      iEn = 1'b0;
      chk("clear_oData0", 32'(oData[0]), 32'(exp0));
      chk("clear_oData1", 32'(oData[1]), 32'(exp1));
    end else begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_oValid", 32'(oValid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_oData0", 32'(oData[0]), 32'(exp0));
      chk("rst_oData1", 32'(oData[1]), 32'(exp1));
      @(negedge clk);
      #2 rst_n = 1'b1;
      iEn = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    start = 1'b0;
    clear = 1'b0;
    iEn = 1'b0;
    iBit = '0;
    oReady = 1'b0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_oValid", 32'(oValid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_oData0", 32'(oData[0]), 32'd0);
    chk("reset_oData1", 32'(oData[1]), 32'd0);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // All-ones lane saturates, all-zeros lane decodes to 0.
    do_window(0, -1, 0, lat);
    chk("sat_latency", 32'(lat), 32'd16);
    chk("sat_oData0", 32'(oData[0]), 32'd15);
    chk("sat_oData1", 32'(oData[1]), 32'd0);
    accept(0, 1'b0);

    // Alternating lane and Sobol-compare stream for 11.
    do_window(1, -1, 0, lat);
    chk("sobol_latency", 32'(lat), 32'd16);
    chk("sobol_oData0", 32'(oData[0]), 32'd8);
    chk("sobol_oData1", 32'(oData[1]), 32'd11);
    accept(3, 1'b0);
    chk("held_oData1", 32'(oData[1]), 32'd11);

    // Back-to-back start with a five-cycle enable gap mid-window.
    do_window(1, 7, 5, lat);
    chk("gap_latency", 32'(lat), 32'd21);
    chk("gap_oData0", 32'(oData[0]), 32'd8);
    chk("gap_oData1", 32'(oData[1]), 32'd11);
    accept(1, 1'b1);

    // clear beats start in idle.
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    chk("clr_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("clr_start_busy2", 32'(busy), 32'd0);

    abort_window(1'b0, 8, 11);
    abort_window(1'b1, 0, 0);

    // Random windows with random enable gaps and consumer stalls.
    for (int r = 0; r < 8; r++) begin
      do_window(2, -1, 0, lat);
      accept($urandom_range(3), 1'b0);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
